// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready channel between the fetch stage and
// instruction memory; data is valid in the same cycle as ready.
interface fetch_stage_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_data;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a wait-state capable
// memory channel, and feeds IF/ID with bubbles, redirects and a stall buffer.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_INC   = 16'd1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          stall,
   input  logic          branchTaken,
   input  logic [15:0]   branchTarget,
   fetch_stage_if.master imem,
   output logic [15:0]   programCounter,
   output logic [15:0]   instructionMemory,
   output logic          flush
);

   typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

   state_t      state, state_next;
   logic [15:0] pc, pc_next;
   logic [15:0] out_pc, out_pc_next;
   logic [15:0] out_inst, out_inst_next;
   logic [15:0] pend_pc, pend_pc_next;
   logic [15:0] pend_inst, pend_inst_next;

   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values computed by the combinational block.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         out_pc    <= '0;
         out_inst  <= '0;
         pend_pc   <= '0;
         pend_inst <= '0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         out_pc    <= out_pc_next;
         out_inst  <= out_inst_next;
         pend_pc   <= pend_pc_next;
         pend_inst <= pend_inst_next;
      end
   end

   always_comb begin
      // NOTE: hold-by-default assignments first, so no path leaves a
      // signal unassigned and no latch is inferred.
      state_next     = state;
      pc_next        = pc;
      out_pc_next    = out_pc;
      out_inst_next  = out_inst;
      pend_pc_next   = pend_pc;
      pend_inst_next = pend_inst;

      if (branchTaken) begin
         // Redirect wins over stall and discards any in-flight or pending word.
         pc_next        = branchTarget;
         out_pc_next    = '0;
         out_inst_next  = '0;
         pend_pc_next   = '0;
         pend_inst_next = '0;
         state_next     = REQ;
      end else begin
         case (state)
            BOOT: state_next = REQ;
            REQ: begin
               if (imem.imem_ready) begin
                  pc_next = pc + PC_INC;
                  if (stall) begin
                     pend_pc_next   = pc;
                     pend_inst_next = imem.imem_data;
                     state_next     = HOLD;
                  end else begin
                     out_pc_next   = pc;
                     out_inst_next = imem.imem_data;
                  end
               end else if (!stall) begin
                  out_pc_next   = '0;
                  out_inst_next = '0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  out_pc_next   = pend_pc;
                  out_inst_next = pend_inst;
                  state_next    = REQ;
               end
            end
            default: state_next = BOOT;
         endcase
      end
   end

   assign imem.imem_req     = (state == REQ);
   assign imem.imem_addr    = pc;
   assign programCounter    = out_pc;
   assign instructionMemory = out_inst;
   assign flush             = branchTaken;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_fetch_stage;

   localparam logic [15:0] PC_INC = 16'd1;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branchTaken;
   logic [15:0] branchTarget;
   logic [15:0] programCounter;
   logic [15:0] instructionMemory;
   logic        flush;

   int errors = 0;
   int checks = 0;

   fetch_stage_if mem_bus ();

   fetch_stage dut (
      .clock             (clock),
      .reset             (reset),
      .stall             (stall),
      .branchTaken       (branchTaken),
      .branchTarget      (branchTarget),
      .imem              (mem_bus),
      .programCounter    (programCounter),
      .instructionMemory (instructionMemory),
      .flush             (flush)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a + 16'h1000;
   endfunction

   assign mem_bus.imem_data = mem_word(mem_bus.imem_addr);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: the presented pair, the PC, a boot flag and a
   // queue holding at most one word captured during a stall.
   logic [15:0] m_pc;
   logic [31:0] m_out;
   logic        m_boot;
   logic [31:0] m_pend[$];

   task automatic model_reset();
      m_pc   = 16'h0000;
      m_out  = '0;
      m_boot = 1'b1;
      m_pend.delete();
   endtask

   task automatic model_step(input logic s, input logic r, input logic b, input logic [15:0] t);
      logic [31:0] fetched;
      if (b) begin
         m_pc  = t;
         m_out = '0;
         m_pend.delete();
         m_boot = 1'b0;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_pend.size() != 0) begin
         if (!s) m_out = m_pend.pop_front();
      end else if (r) begin
         fetched = {m_pc, mem_word(m_pc)};
         m_pc    = m_pc + PC_INC;
         if (s) m_pend.push_back(fetched);
         else   m_out = fetched;
      end else if (!s) begin
         m_out = '0;
      end
   endtask

   // Drive one cycle's inputs at the falling edge, clock once, return at the next falling edge.
   task automatic tick(input logic s, input logic r, input logic b, input logic [15:0] t);
      stall = s; mem_bus.imem_ready = r; branchTaken = b; branchTarget = t;
      @(posedge clock);
      model_step(s, r, b, t);
      @(negedge clock);
   endtask

   task automatic expect_out(input string name, input logic [15:0] epc, input logic [15:0] einst);
      checks++;
      if ({programCounter, instructionMemory} !== {epc, einst}) begin
         errors++;
         $display("FAIL %s: got (%h,%h) want (%h,%h)", name, programCounter, instructionMemory, epc, einst);
      end
   endtask

   task automatic expect_bus(input string name, input logic ereq, input logic [15:0] eaddr);
      checks++;
      if ({mem_bus.imem_req, mem_bus.imem_addr} !== {ereq, eaddr}) begin
         errors++;
         $display("FAIL %s: got req=%b addr=%h want req=%b addr=%h", name, mem_bus.imem_req, mem_bus.imem_addr, ereq, eaddr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; mem_bus.imem_ready = 1'b0;
      model_reset();
      @(negedge clock);
      expect_bus("reset_bus", 1'b0, 16'h0000);
      expect_out("reset_out", 16'h0000, 16'h0000);
      branchTaken = 1'b1;
      #1;
      checks++;
      if (flush !== 1'b1) begin
         errors++;
         $display("FAIL reset_flush: got %b want 1", flush);
      end
      branchTaken = 1'b0;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_flush_low: got %b want 0", flush);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      tick(0, 1, 0, 0);
      expect_bus("boot_to_req", 1'b1, 16'h0000);
      expect_out("boot_out", 16'h0000, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         tick(0, 1, 0, 0);
         expect_out("seq_out", 16'(i), 16'h1000 + 16'(i));
      end
      expect_bus("seq_addr", 1'b1, 16'h0005);
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 2; i++) begin
         tick(0, 0, 0, 0);
         expect_out("wait_bubble", 16'h0000, 16'h0000);
         expect_bus("wait_addr", 1'b1, 16'h0005);
      end
      tick(0, 1, 0, 0);
      expect_out("wait_done", 16'h0005, 16'h1005);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      expect_out("pre_stall", 16'h0007, 16'h1007);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         tick(1, 1, 0, 0);
         expect_out("stall_hold", 16'h0007, 16'h1007);
         expect_bus("stall_req", 1'b0, 16'h0009);
      end
      tick(0, 1, 0, 0);
      expect_out("stall_release", 16'h0008, 16'h1008);
      expect_bus("stall_resume", 1'b1, 16'h0009);
      tick(0, 1, 0, 0);
      expect_out("stall_next", 16'h0009, 16'h1009);
   endtask

   task automatic test_branch();
      stall = 1'b0; mem_bus.imem_ready = 1'b1; branchTaken = 1'b1; branchTarget = 16'h0040;
      #1;
      checks++;
      if (flush !== 1'b1) begin
         errors++;
         $display("FAIL branch_flush: got %b want 1", flush);
      end
      tick(0, 1, 1, 16'h0040);
      expect_out("branch_zero", 16'h0000, 16'h0000);
      expect_bus("branch_addr", 1'b1, 16'h0040);
      tick(0, 1, 0, 0);
      expect_out("branch_target", 16'h0040, 16'h1040);
      // Redirect while stalled with a word already pending: pending word must vanish.
      tick(1, 1, 0, 0);
      tick(1, 1, 1, 16'h0040);
      expect_out("branch_stall_zero", 16'h0000, 16'h0000);
      expect_bus("branch_stall_addr", 1'b1, 16'h0040);
      tick(0, 1, 0, 0);
      expect_out("branch_stall_target", 16'h0040, 16'h1040);
   endtask

   task automatic test_wrap();
      tick(0, 1, 1, 16'hFFFF);
      tick(0, 1, 0, 0);
      expect_out("wrap_last", 16'hFFFF, 16'h0FFF);
      expect_bus("wrap_addr", 1'b1, 16'h0000);
      tick(0, 1, 0, 0);
      expect_out("wrap_first", 16'h0000, 16'h1000);
   endtask

   task automatic test_reset_mid();
      tick(0, 0, 1, 16'h0123);
      tick(0, 0, 0, 0);
      expect_bus("mid_wait", 1'b1, 16'h0123);
      #2 reset = 1'b0;
      #1;
      model_reset();
      expect_bus("mid_reset_bus", 1'b0, 16'h0000);
      expect_out("mid_reset_out", 16'h0000, 16'h0000);
      @(negedge clock);
      reset = 1'b1;
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      expect_out("restart", 16'h0000, 16'h1000);
      tick(1, 1, 0, 0);
      expect_bus("hold_before_reset", 1'b0, 16'h0002);
      #2 reset = 1'b0;
      #1;
      model_reset();
      expect_bus("hold_reset_bus", 1'b0, 16'h0000);
      expect_out("hold_reset_out", 16'h0000, 16'h0000);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_random();
      logic s, r, b;
      logic [15:0] t;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 99) < 30);
         r = ($urandom_range(0, 99) < 60);
         b = ($urandom_range(0, 99) < 8);
         t = 16'($urandom);
         tick(s, r, b, t);
         checks++;
         if ({programCounter, instructionMemory} !== m_out) begin
            errors++;
            $display("FAIL rand_out cycle %0d: got (%h,%h) want (%h,%h)", i, programCounter, instructionMemory, m_out[31:16], m_out[15:0]);
         end
         checks++;
         if ({mem_bus.imem_req, mem_bus.imem_addr} !== {(!m_boot && m_pend.size() == 0), m_pc}) begin
            errors++;
            $display("FAIL rand_bus cycle %0d: got req=%b addr=%h want req=%b addr=%h", i, mem_bus.imem_req, mem_bus.imem_addr, (!m_boot && m_pend.size() == 0), m_pc);
         end
         checks++;
         if (flush !== b) begin
            errors++;
            $display("FAIL rand_flush cycle %0d: got %b want %b", i, flush, b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_stall();
      test_branch();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
